// File: rtl/iserdes_pkg.sv
// Shared definitions for the ISERDES2 frame aligner: FSM state encoding,
// counter width and the default frame-lane training pattern.
package iserdes_pkg;

  // Alignment FSM states; encoding is fixed so debug probes can decode it.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } align_state_e;

  // Width of the match / miss / slip / wait counters (all limits are <= 15).
  localparam int CNT_W = 4;

  // Frame-lane word expected when the deserializers are word aligned.
  localparam logic [7:0] DEFAULT_FRAME_PATTERN = 8'hF0;

endpackage

// File: rtl/iserdes_frame_fsm.sv
// Word-alignment trainer: compares the frame lane against the programmed
// pattern, issues bitslip pulses until it matches MATCH_CNT times in a row,
// then watches for MISS_MAX consecutive mismatches to trigger a retrain.
module iserdes_frame_fsm
  import iserdes_pkg::*;
#(
  parameter int         DW            = 8,
  parameter logic [7:0] FRAME_PATTERN = DEFAULT_FRAME_PATTERN,
  parameter int         MATCH_CNT     = 4,
  parameter int         MISS_MAX      = 2,
  parameter int         SLIP_WAIT     = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          train_i,
  input  logic [DW-1:0] frame_word_i,
  output logic          bitslip_o,
  output logic          locked_o,
  output logic          lock_next_o,
  output logic          align_err_o
);

  localparam logic [DW-1:0]    PAT        = FRAME_PATTERN[DW-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MATCH_LAST = CNT_W'(MATCH_CNT - 1);
  localparam logic [CNT_W-1:0] MISS_LAST  = CNT_W'(MISS_MAX - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(SLIP_WAIT - 1);
  localparam logic [CNT_W-1:0] SLIP_LIMIT = CNT_W'(DW);

  align_state_e     state_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;
  logic [CNT_W-1:0] slip_cnt_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             bitslip_q;
  logic             locked_q;
  logic             align_err_q;
  logic             match_s;
  logic             lock_d;

  assign match_s = (frame_word_i == PAT);

  // Next value of the lock flag; shared with the top so dout_valid tracks locked exactly.
  always_comb begin
    lock_d = 1'b0;
    if (train_i && (state_q == ST_CHECK) && match_s && (match_cnt_q == MATCH_LAST)) begin
      lock_d = 1'b1;
    end else if (train_i && (state_q == ST_LOCKED) && !(!match_s && (miss_cnt_q == MISS_LAST))) begin
      lock_d = 1'b1;
    end else begin
      lock_d = 1'b0;
    end
  end

  // Alignment FSM with its counters and registered bitslip/locked/align_err outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      slip_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      bitslip_q   <= 1'b0;
      locked_q    <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      locked_q  <= lock_d;
      if (!train_i) begin
        // Dropping train wins over everything, including a pending slip.
        state_q     <= ST_IDLE;
        match_cnt_q <= '0;
        miss_cnt_q  <= '0;
        slip_cnt_q  <= '0;
        wait_cnt_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            slip_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            align_err_q <= 1'b0;
            state_q     <= ST_CHECK;
          end
          ST_CHECK: begin
            if (match_s) begin
              if (match_cnt_q == MATCH_LAST) begin
                state_q     <= ST_LOCKED;
                match_cnt_q <= '0;
                miss_cnt_q  <= '0;
                slip_cnt_q  <= '0;
              end else begin
                match_cnt_q <= match_cnt_q + CNT_ONE;
              end
            end else begin
              // The pulse is launched on the edge entering SLIP, unless slips are exhausted.
              match_cnt_q <= '0;
              state_q     <= ST_SLIP;
              bitslip_q   <= (slip_cnt_q != SLIP_LIMIT);
            end
          end
          ST_SLIP: begin
            if (slip_cnt_q == SLIP_LIMIT) begin
              state_q     <= ST_FAIL;
              align_err_q <= 1'b1;
            end else begin
              slip_cnt_q <= slip_cnt_q + CNT_ONE;
              wait_cnt_q <= '0;
              state_q    <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
              wait_cnt_q <= '0;
              state_q    <= ST_CHECK;
            end else begin
              wait_cnt_q <= wait_cnt_q + CNT_ONE;
            end
          end
          ST_LOCKED: begin
            if (match_s) begin
              miss_cnt_q <= '0;
            end else if (miss_cnt_q == MISS_LAST) begin
              miss_cnt_q  <= '0;
              match_cnt_q <= '0;
              wait_cnt_q  <= '0;
              state_q     <= ST_CHECK;
            end else begin
              miss_cnt_q <= miss_cnt_q + CNT_ONE;
            end
          end
          ST_FAIL: begin
            state_q <= ST_FAIL;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bitslip_o   = bitslip_q;
  assign locked_o    = locked_q;
  assign lock_next_o = lock_d;
  assign align_err_o = align_err_q;

endmodule

// File: rtl/iserdes_frame_aligner.sv
// Multi-channel ISERDES2 frame aligner (clkdiv domain). Trains word alignment
// via the frame lane and assembles each channel's A/B lane words into one
// 2*DW-bit sample. Optional build macro ISERDES_ALIGN_STATS_EN adds saturating
// slip_total / miss_total statistics outputs.
module iserdes_frame_aligner
  import iserdes_pkg::*;
#(
  parameter int         NCH           = 4,
  parameter int         DW            = 8,
  parameter logic [7:0] FRAME_PATTERN = DEFAULT_FRAME_PATTERN,
  parameter int         MATCH_CNT     = 4,
  parameter int         MISS_MAX      = 2,
  parameter int         SLIP_WAIT     = 3
) (
  input  logic                  clkdiv,
  input  logic                  reset_n,
  input  logic                  train,
  input  logic [DW-1:0]         frame_word,
  input  logic [NCH*DW-1:0]     lane_a,
  input  logic [NCH*DW-1:0]     lane_b,
  output logic                  bitslip,
  output logic                  locked,
  output logic                  align_err,
  output logic [NCH*2*DW-1:0]   dout,
  output logic                  dout_valid
`ifdef ISERDES_ALIGN_STATS_EN
  ,
  output logic [7:0]            slip_total,
  output logic [15:0]           miss_total
`endif
);

  logic lock_next_s;
  logic dout_valid_q;

  iserdes_frame_fsm #(
    .DW            (DW),
    .FRAME_PATTERN (FRAME_PATTERN),
    .MATCH_CNT     (MATCH_CNT),
    .MISS_MAX      (MISS_MAX),
    .SLIP_WAIT     (SLIP_WAIT)
  ) u_fsm (
    .clk_i        (clkdiv),
    .rst_ni       (reset_n),
    .train_i      (train),
    .frame_word_i (frame_word),
    .bitslip_o    (bitslip),
    .locked_o     (locked),
    .lock_next_o  (lock_next_s),
    .align_err_o  (align_err)
  );

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [2*DW-1:0] dout_q;

    // Capture {A,B} for this channel; zero whenever the link will not be locked.
    always_ff @(posedge clkdiv or negedge reset_n) begin
      if (!reset_n) begin
        dout_q <= '0;
      end else if (lock_next_s) begin
        dout_q <= {lane_a[k*DW +: DW], lane_b[k*DW +: DW]};
      end else begin
        dout_q <= '0;
      end
    end

    assign dout[k*2*DW +: 2*DW] = dout_q;
  end

  // dout_valid is loaded from the same next-lock term as locked, so they stay identical.
  always_ff @(posedge clkdiv or negedge reset_n) begin
    if (!reset_n) begin
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= lock_next_s;
    end
  end

  assign dout_valid = dout_valid_q;

`ifdef ISERDES_ALIGN_STATS_EN
  localparam logic [DW-1:0] PAT = FRAME_PATTERN[DW-1:0];

  logic [7:0]  slip_total_q;
  logic [15:0] miss_total_q;

  // Saturating event counters: issued bitslip pulses and frame misses while locked.
  always_ff @(posedge clkdiv or negedge reset_n) begin
    if (!reset_n) begin
      slip_total_q <= 8'd0;
      miss_total_q <= 16'd0;
    end else begin
      if (bitslip && (slip_total_q != 8'hFF)) begin
        slip_total_q <= slip_total_q + 8'd1;
      end else begin
        slip_total_q <= slip_total_q;
      end
      if (locked && (frame_word != PAT) && (miss_total_q != 16'hFFFF)) begin
        miss_total_q <= miss_total_q + 16'd1;
      end else begin
        miss_total_q <= miss_total_q;
      end
    end
  end

  assign slip_total = slip_total_q;
  assign miss_total = miss_total_q;
`endif

endmodule

// File: tb/tb_iserdes_frame_aligner.sv
// Self-checking bench for iserdes_frame_aligner (NCH=4, DW=8, defaults).
// The frame lane is modelled as a word that rotates left by one bit for each
// bitslip pulse, two cycles after the pulse. Build with ISERDES_ALIGN_STATS_EN
// defined to also check the statistics outputs.
module tb_iserdes_frame_aligner;
  import iserdes_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int MATCH_CNT = 4;
  localparam int SLIP_WAIT = 3;

  logic                clkdiv = 1'b0;
  logic                reset_n;
  logic                train;
  logic [DW-1:0]       frame_word;
  logic [NCH*DW-1:0]   lane_a;
  logic [NCH*DW-1:0]   lane_b;
  logic                bitslip;
  logic                locked;
  logic                align_err;
  logic [NCH*2*DW-1:0] dout;
  logic                dout_valid;
`ifdef ISERDES_ALIGN_STATS_EN
  logic [7:0]          slip_total;
  logic [15:0]         miss_total;
`endif

  iserdes_frame_aligner #(.NCH(NCH), .DW(DW)) dut (
    .clkdiv     (clkdiv),
    .reset_n    (reset_n),
    .train      (train),
    .frame_word (frame_word),
    .lane_a     (lane_a),
    .lane_b     (lane_b),
    .bitslip    (bitslip),
    .locked     (locked),
    .align_err  (align_err),
    .dout       (dout),
    .dout_valid (dout_valid)
`ifdef ISERDES_ALIGN_STATS_EN
    ,
    .slip_total (slip_total),
    .miss_total (miss_total)
`endif
  );

  always #5 clkdiv = ~clkdiv;

  // Model state
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  base;
  logic [7:0]  corrupt;
  logic [31:0] a_raw, b_raw;
  int          rot, cyc, pulses, last_pulse, min_gap;
  bit          p1, p2;

  typedef struct {
    logic [7:0] start;
    int         slips;
    bit         fail;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [7:0] rotl8(input logic [7:0] w, input int n);
    logic [7:0] r;
    r = w;
    for (int i = 0; i < (n % 8); i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [63:0] pack(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'd0;
    for (int k = 0; k < NCH; k++) p[k*16 +: 16] = {a[k*8 +: 8], b[k*8 +: 8]};
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    frame_word = rotl8(base, rot) ^ corrupt;
    lane_a     = a_raw;
    lane_b     = b_raw;
  endtask

  // One clkdiv cycle: outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clkdiv);
    #1;
    cyc++;
    if (p2) rot++;
    p2 = p1;
    p1 = bitslip;
    if (bitslip) begin
      if (pulses > 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
      pulses++;
      last_pulse = cyc;
    end
    drive();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    train   = 1'b0;
    base    = 8'hF0;
    corrupt = 8'h00;
    a_raw   = 32'd0;
    b_raw   = 32'd0;
    rot = 0; p1 = 1'b0; p2 = 1'b0;
    drive();
    repeat (2) @(posedge clkdiv);
    #1;
    reset_n = 1'b1;
    cyc = 0; pulses = 0; last_pulse = 0; min_gap = 1000;
  endtask

  task automatic lock_up();
    train = 1'b1;
    drive();
    for (int i = 0; i < 60 && !locked; i++) tick();
    check("lock_up", {63'd0, locked}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0, off, exp_miss;
    bit   prev_c, c;
    logic [63:0] exp_d;

    // Reset state
    do_reset();
    check("rst_outputs", {59'd0, bitslip, locked, align_err, dout_valid, 1'b0}, 64'd0);
    check("rst_dout", dout, 64'd0);
    check("rst_state", 64'(dut.u_fsm.state_q), 64'(ST_IDLE));

    // Training vectors: starting frame word, slips needed, whether alignment fails
    vecs[0] = '{8'hF0, 0, 1'b0};
    vecs[1] = '{8'h1E, 3, 1'b0};
    vecs[2] = '{8'h00, 8, 1'b1};
    vecs[3] = '{8'h87, 5, 1'b0};
    vecs[4] = '{8'hFF, 8, 1'b1};
    for (int i = 5; i < 8; i++) begin
      int s;
      s = $urandom_range(7);
      vecs[i] = '{rotl8(8'hF0, s), (8 - s) % 8, 1'b0};
    end

    for (int i = 0; i < 8; i++) begin
      do_reset();
      base  = vecs[i].start;
      train = 1'b1;
      drive();
      tick();                // first CHECK cycle
      t0 = cyc;
      for (int n = 0; n < 200 && !locked && !align_err; n++) tick();
      off = cyc - t0;
      check($sformatf("v%0d_pulses", i), 64'(pulses), 64'(vecs[i].slips));
      check($sformatf("v%0d_gap_ok", i), {63'd0, (min_gap >= SLIP_WAIT + 2)}, 64'd1);
      if (vecs[i].fail) begin
        check($sformatf("v%0d_fail_time", i), 64'(off), 64'(5 * DW + 2));
        check($sformatf("v%0d_align_err", i), {63'd0, align_err}, 64'd1);
        check($sformatf("v%0d_locked", i), {63'd0, locked}, 64'd0);
        check($sformatf("v%0d_dout", i), dout, 64'd0);
        train = 1'b0; drive(); tick();
        check($sformatf("v%0d_err_sticky", i), {63'd0, align_err}, 64'd1);
        train = 1'b1; drive(); tick();
        check($sformatf("v%0d_err_clear", i), {63'd0, align_err}, 64'd0);
      end else begin
        check($sformatf("v%0d_lock_time", i), 64'(off), 64'(5 * vecs[i].slips + MATCH_CNT));
        check($sformatf("v%0d_valid", i), {63'd0, dout_valid}, 64'd1);
      end
`ifdef ISERDES_ALIGN_STATS_EN
      check($sformatf("v%0d_slip_total", i), 64'(slip_total), 64'(vecs[i].slips));
`endif
    end

    // Locked link: isolated miss, channel packing, random data scoreboard
    do_reset();
    lock_up();
    corrupt = 8'h5A; drive(); tick();
    corrupt = 8'h00; drive();
    check("single_miss_locked", {63'd0, locked}, 64'd1);
`ifdef ISERDES_ALIGN_STATS_EN
    check("single_miss_total", 64'(miss_total), 64'd1);
`endif
    exp_miss = 1;
    a_raw = $urandom; a_raw[23:16] = 8'hA5;
    b_raw = $urandom; b_raw[23:16] = 8'h3C;
    drive(); tick();
    check("ch2_pack", {48'd0, dout[47:32]}, 64'hA53C);

    prev_c = 1'b0;
    for (int n = 0; n < 30; n++) begin
      a_raw = $urandom;
      b_raw = $urandom;
      c = !prev_c && ($urandom_range(3) == 0);
      corrupt = c ? 8'($urandom_range(255, 1)) : 8'h00;
      if (c) exp_miss++;
      prev_c = c;
      exp_d = pack(a_raw, b_raw);
      drive(); tick();
      check("rand_dout", dout, exp_d);
      check("rand_locked", {63'd0, locked}, 64'd1);
    end
    corrupt = 8'h00; drive(); tick();
`ifdef ISERDES_ALIGN_STATS_EN
    check("rand_miss_total", 64'(miss_total), 64'(exp_miss));
`endif

    // Two consecutive misses drop lock and retrain from CHECK without slipping
    corrupt = 8'h01; drive(); tick();
    check("miss1_locked", {63'd0, locked}, 64'd1);
    tick();
    check("miss2_unlocked", {63'd0, locked}, 64'd0);
    check("miss2_valid", {63'd0, dout_valid}, 64'd0);
    check("miss2_dout", dout, 64'd0);
    corrupt = 8'h00; drive();
    repeat (MATCH_CNT - 1) tick();
    check("relock_early", {63'd0, locked}, 64'd0);
    tick();
    check("relock", {63'd0, locked}, 64'd1);
    check("relock_no_slip", 64'(pulses), 64'd0);

    // Train falls in the same cycle as a CHECK mismatch: IDLE, no slip
    do_reset();
    base = 8'h1E; train = 1'b1; drive();
    tick();
    train = 1'b0; drive();
    tick();
    check("trainfall_bitslip", {63'd0, bitslip}, 64'd0);
    check("trainfall_state", 64'(dut.u_fsm.state_q), 64'(ST_IDLE));

    // Reset asserted while bitslip is high drops it asynchronously
    do_reset();
    base = 8'h1E; train = 1'b1; drive();
    for (int n = 0; n < 10 && !bitslip; n++) tick();
    check("slip_seen", {63'd0, bitslip}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_slip", {63'd0, bitslip}, 64'd0);

    // Reset asserted during WAIT clears outputs at once and returns to IDLE
    do_reset();
    base = 8'h1E; train = 1'b1; drive();
    for (int n = 0; n < 10 && !bitslip; n++) tick();
    tick(); tick();
    check("in_wait", 64'(dut.u_fsm.state_q), 64'(ST_WAIT));
    reset_n = 1'b0; train = 1'b0;
    #1;
    check("rst_wait_outs", {60'd0, bitslip, locked, align_err, dout_valid}, 64'd0);
    check("rst_wait_dout", dout, 64'd0);
    @(posedge clkdiv); #1;
    reset_n = 1'b1;
    tick();
    check("rst_wait_idle", 64'(dut.u_fsm.state_q), 64'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iserdes_frame_aligner.md
# iserdes_frame_aligner

Parametrised successor to the single-lane fixed-width ISERDES2 frame PHY. It runs in the `clkdiv` domain behind NCH channels of two-lane (A/B) ISERDES2 primitives plus one frame-clock lane. It trains word alignment automatically by issuing bitslip pulses until the frame lane matches a programmed pattern. Once locked, it assembles each channel's A/B lane words into one 2·DW-bit sample and monitors the frame lane for loss of lock.

## Interface
Parameters:
- `NCH`, 4: number of ADC channels, 1..8.
- `DW`, 8: bits per lane per `clkdiv` cycle, 1..8. Replaces the old OUTPUT_MODE encoding.
- `FRAME_PATTERN`, 8'hF0: expected frame-lane word; only bits [DW-1:0] are used.
- `MATCH_CNT`, 4: consecutive matches required to declare lock, 1..15.
- `MISS_MAX`, 2: consecutive mismatches in LOCKED that drop lock, 1..15.
- `SLIP_WAIT`, 3: `clkdiv` cycles to wait after a bitslip before comparing again, 1..15.

Ports:
- `clkdiv`  in  1  sole clock; parallel-word clock of the ISERDES2 primitives.
- `reset_n`  in  1  asynchronous, active-low reset.
- `train`  in  1  level; 1 = run/keep alignment, 0 = return to IDLE.
- `frame_word`  in  DW  parallel word from the frame lane.
- `lane_a`  in  NCH·DW  A-lane words; channel k occupies [k·DW +: DW].
- `lane_b`  in  NCH·DW  B-lane words, same packing as `lane_a`.
- `bitslip`  out  1  one-cycle pulse, fanned out to every ISERDES2 including the frame lane.
- `locked`  out  1  alignment achieved.
- `align_err`  out  1  sticky; set when DW slips complete without lock.
- `dout`  out  NCH·2·DW  channel k = {lane_a_k, lane_b_k} at [k·2DW +: 2DW].
- `dout_valid`  out  1  `dout` holds aligned data.

## Operation
- FSM states: IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL.
- IDLE: match_cnt, miss_cnt and slip_cnt are cleared. When `train`=1, go to CHECK.
- CHECK: compare `frame_word` with FRAME_PATTERN[DW-1:0].
  - Match: match_cnt++. When match_cnt reaches MATCH_CNT, go to LOCKED.
  - Mismatch: clear match_cnt and go to SLIP.
- SLIP: pulse `bitslip`, increment slip_cnt, then go to WAIT.
  - If slip_cnt already equals DW on entry to SLIP, go to FAIL instead and issue no pulse.
- WAIT: count SLIP_WAIT cycles, then go to CHECK. Frame words are ignored during WAIT.
- LOCKED: a mismatch increments miss_cnt; a match clears it. When miss_cnt reaches MISS_MAX, go to CHECK with all counters cleared (retrain).
- FAIL: set `align_err`. Leave FAIL only when `train`=0, which goes to IDLE.
- In any state, `train`=0 goes to IDLE on the next edge.
- `align_err` clears only on reset or on an IDLE→CHECK transition.
- slip_cnt is cleared when lock is reached. It is not cleared per retrain, so a link that keeps slipping eventually lands in FAIL.

## Timing
- All outputs are registered.
- Reset values: `bitslip`=0, `locked`=0, `align_err`=0, `dout`=0, `dout_valid`=0. FSM resets to IDLE with all counters 0.
- `bitslip` is high for exactly one cycle: the cycle after the edge that enters SLIP. Two pulses are always separated by at least SLIP_WAIT+2 cycles.
- `locked` rises on the edge that enters LOCKED. It falls on the edge that leaves LOCKED.
- `dout` has 1-cycle latency from `lane_a`/`lane_b`. `dout_valid` equals `locked`. While `dout_valid`=0, `dout` is forced to 0.
- If `train` falls and a mismatch occurs in the same cycle, `train` has priority: go to IDLE, no slip.
- If reset asserts mid-slip, `bitslip` drops asynchronously.

## Configuration
- `ISERDES_ALIGN_STATS_EN` defined adds two outputs:
  - `slip_total` (8 bits): saturating count of `bitslip` pulses since reset.
  - `miss_total` (16 bits): saturating count of frame mismatches while LOCKED.
  - Both reset to 0.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `iserdes_pkg`:
  - FSM state encoding (IDLE=0, CHECK=1, SLIP=2, WAIT=3, LOCKED=4, FAIL=5).
  - Counter width constant (4 bits).
  - Default FRAME_PATTERN.
- Sub-module `iserdes_frame_fsm`: FSM, counters and `bitslip`/`locked`/`align_err`.
- Top level adds the per-channel output register generate loop and the stats counters.

## Test plan
Bench model: each `bitslip` pulse rotates every lane's word left by 1 bit, effective 2 cycles later. DW=8, NCH=4, defaults otherwise.
- Frame starts aligned at 0xF0, `train`=1 → no `bitslip`; `locked`=1 four cycles after CHECK entry; `dout_valid`=1.
- Frame starts at 0x1E → exactly 3 `bitslip` pulses, each ≥5 cycles apart. Then `locked`=1 with `slip_total`=3 (stats build).
- Frame constant 0x00 → 8 pulses, then `align_err`=1, `locked`=0, `dout`=0. After `train`=0 then 1, `align_err` clears.
- Locked; `lane_a`_2=0xA5, `lane_b`_2=0x3C → next cycle `dout`[47:32]=0xA53C.
- Locked; one corrupted frame word → still locked, `miss_total`=1. Two consecutive corrupted words → `locked` falls and retraining starts.
- Assert `reset_n`=0 during WAIT → all outputs 0 immediately. After release, FSM is in IDLE.
